// File: rtl/pool_pkg.sv
// Shared constants and element type for the 2x2 max-pooling datapath.
// Also used by the convolution demux and the main buffer.
package pool_pkg;
    localparam int POOL_DATA_WIDTH = 32;
    localparam int POOL_FMAP_W     = 8;
    localparam int POOL_FMAP_H     = 8;

    typedef logic signed [POOL_DATA_WIDTH-1:0] pool_elem_t;

    // Counter/index width for a range of values, never narrower than one bit.
    function automatic int cnt_width(input int range);
        return (range > 1) ? $clog2(range) : 1;
    endfunction
endpackage

// File: rtl/pool_line_buf.sv
// Half-row line buffer: holds the horizontal maxima of the even row until
// the matching odd row arrives. One write port, asynchronous read.
module pool_line_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int AW         = 2
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    // No reset: every entry is rewritten on the even row before it is read.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/max_pooling_2x2.sv
// Streaming 2x2 / stride-2 signed max pooling over a row-major feature map,
// with a single-entry output register and valid/ready handshakes.
module max_pooling_2x2
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = POOL_DATA_WIDTH,
    parameter int FMAP_W     = POOL_FMAP_W,
    parameter int FMAP_H     = POOL_FMAP_H
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last
);
    localparam int CW       = cnt_width(FMAP_W);
    localparam int RW       = cnt_width(FMAP_H);
    localparam int LB_DEPTH = FMAP_W / 2;
    localparam int LW       = cnt_width(LB_DEPTH);

    logic [CW-1:0] col, col_nxt;
    logic [RW-1:0] row, row_nxt;
    logic [LW-1:0] lb_idx;

    logic signed [DATA_WIDTH-1:0] in_s;
    logic signed [DATA_WIDTH-1:0] pair;
    logic signed [DATA_WIDTH-1:0] h;
    logic signed [DATA_WIDTH-1:0] lb_rd;
    logic signed [DATA_WIDTH-1:0] pool;
    logic [DATA_WIDTH-1:0]        lb_rdata;

    logic in_xfer, out_xfer;
    logic col_end, row_end;
    logic lb_we, out_load, frame_end;

    // Only out_ready reaches in_ready combinationally.
    assign in_ready = !out_valid || out_ready;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;

    assign col_end = (col == CW'(FMAP_W - 1));
    assign row_end = (row == RW'(FMAP_H - 1));

    always_comb begin
        col_nxt = col;
        row_nxt = row;
        if (col_end) begin
            col_nxt = '0;
            row_nxt = row_end ? '0 : row + 1'b1;
        end else begin
            col_nxt = col + 1'b1;
        end
    end

    assign in_s   = in_data;
    assign lb_idx = LW'(col >> 1);
    assign lb_rd  = lb_rdata;

    // Ties pick either operand; both carry the same value.
    assign h    = (pair >= in_s) ? pair : in_s;
    assign pool = (h >= lb_rd) ? h : lb_rd;

    assign lb_we     = in_xfer && col[0] && !row[0];
    assign out_load  = in_xfer && col[0] && row[0];
    assign frame_end = row_end && col_end;

    always_ff @(posedge clk) begin
        if (rst) begin
            col  <= '0;
            row  <= '0;
            pair <= '0;
        end else if (in_xfer) begin
            col <= col_nxt;
            row <= row_nxt;
            if (!col[0]) pair <= in_s;
        end
    end

    // A load can only happen with in_ready high, so a stalled result is
    // never overwritten; accept-and-load in one cycle keeps out_valid set.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (out_load) begin
            out_valid <= 1'b1;
            out_last  <= frame_end;
            out_data  <= pool;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

    pool_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (LB_DEPTH),
        .AW         (LW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_idx),
        .wdata (h),
        .raddr (lb_idx),
        .rdata (lb_rdata)
    );
endmodule

// File: tb/tb_max_pooling_2x2.sv
// Bench for max_pooling_2x2: three geometries (4x2, 2x2, 8x8) driven from one
// directed sequence, scored against a window-max reference model.
module tb_max_pooling_2x2;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv   [3];
    logic        ir   [3];
    logic        ov   [3];
    logic        ordy [3];
    logic        ol   [3];
    logic [31:0] id   [3];
    logic [31:0] od   [3];

    int total = 0;
    int bad   = 0;
    int acc [3];

    logic [31:0] stim  [$];
    logic [31:0] exp_d [$];
    logic        exp_l [$];
    logic [31:0] fr    [64];

    always #5 clk = ~clk;

    max_pooling_2x2 #(.DATA_WIDTH(32), .FMAP_W(4), .FMAP_H(2)) u_w4h2 (
        .clk(clk), .rst(rst), .in_data(id[0]), .in_valid(iv[0]), .in_ready(ir[0]),
        .out_data(od[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_last(ol[0]));
    max_pooling_2x2 #(.DATA_WIDTH(32), .FMAP_W(2), .FMAP_H(2)) u_w2h2 (
        .clk(clk), .rst(rst), .in_data(id[1]), .in_valid(iv[1]), .in_ready(ir[1]),
        .out_data(od[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_last(ol[1]));
    max_pooling_2x2 #(.DATA_WIDTH(32), .FMAP_W(8), .FMAP_H(8)) u_w8h8 (
        .clk(clk), .rst(rst), .in_data(id[2]), .in_valid(iv[2]), .in_ready(ir[2]),
        .out_data(od[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_last(ol[2]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, $signed(obs), obs, $signed(expv), expv);
        end
    endtask

    function automatic int wd(input int k);
        return (k == 0) ? 4 : (k == 1) ? 2 : 8;
    endfunction

    function automatic int ht(input int k);
        return (k == 2) ? 8 : 2;
    endfunction

    function automatic logic [31:0] smax(input logic [31:0] a, input logic [31:0] b);
        return ($signed(a) > $signed(b)) ? a : b;
    endfunction

    // Reference: queue the frame and the max of every 2x2 window, row-major.
    task automatic add_frame(input int w, input int h);
        for (int i = 0; i < w * h; i++) stim.push_back(fr[i]);
        for (int r = 0; r < h / 2; r++)
            for (int c = 0; c < w / 2; c++) begin
                exp_d.push_back(smax(smax(fr[2*r*w + 2*c], fr[2*r*w + 2*c + 1]),
                                     smax(fr[(2*r+1)*w + 2*c], fr[(2*r+1)*w + 2*c + 1])));
                exp_l.push_back((r == h/2 - 1) && (c == w/2 - 1));
            end
    endtask

    task automatic rand_frame();
        for (int i = 0; i < 64; i++) fr[i] = $urandom;
    endtask

    task automatic clear_model();
        stim.delete();
        exp_d.delete();
        exp_l.delete();
        for (int i = 0; i < 3; i++) acc[i] = 0;
    endtask

    task automatic stream(input int k, input int pv, input int pr, input int stall,
                          input int gap_at, input int max_in, input int budget);
        int cyc = 0, taken = 0, gap = 0, pos;
        bit due = 0, held = 0, gap_done = 0;
        logic [31:0] pd = '0;
        logic pl = 1'b0;
        int w = wd(k), h = ht(k);
        forever begin
            if (max_in > 0 ? taken >= max_in : (stim.size() == 0 && exp_d.size() == 0)) break;
            if (cyc >= budget) begin
                chk("timeout", 32'(cyc), 32'(budget + 1));
                break;
            end
            @(negedge clk);
            if (gap_at >= 0 && taken == gap_at && !gap_done) begin
                gap = 10;
                gap_done = 1;
            end
            iv[k] = (stim.size() > 0) && (gap == 0) && ($urandom_range(99) < pv);
            id[k] = iv[k] ? stim[0] : '0;
            if (gap > 0) gap--;
            ordy[k] = ($urandom_range(99) < pr);
            if (stall > 0 && ov[k]) begin
                ordy[k] = 1'b0;
                stall--;
            end
            #1;
            if (due) chk("latency1", 32'(ov[k]), 32'd1);
            if (held) begin
                chk("hold_valid", 32'(ov[k]), 32'd1);
                chk("hold_data", od[k], pd);
                chk("hold_last", 32'(ol[k]), 32'(pl));
            end
            chk("in_ready", 32'(ir[k]), 32'(!ov[k] || ordy[k]));
            due  = 0;
            held = ov[k] && !ordy[k];
            pd   = od[k];
            pl   = ol[k];
            if (ov[k] && ordy[k]) begin
                if (exp_d.size() == 0) chk("spurious_out", 32'd1, 32'd0);
                else begin
                    chk("out_data", od[k], exp_d.pop_front());
                    chk("out_last", 32'(ol[k]), 32'(exp_l.pop_front()));
                end
            end
            if (iv[k] && ir[k]) begin
                pos = acc[k] % (w * h);
                due = ((pos / w) % 2 == 1) && ((pos % w) % 2 == 1);
                acc[k]++;
                taken++;
                void'(stim.pop_front());
            end
            cyc++;
        end
        @(negedge clk);
        iv[k]   = 1'b0;
        id[k]   = '0;
        ordy[k] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0; id[i] = '0; ordy[i] = 1'b0; acc[i] = 0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_out_valid", 32'(ov[i]), 32'd0);
            chk("rst_out_last", 32'(ol[i]), 32'd0);
            chk("rst_out_data", od[i], 32'd0);
            chk("rst_in_ready", 32'(ir[i]), 32'd1);
        end

        // 4x2 directed frame: 1,5,2,3 / 4,0,7,-1 -> 5, 7(last)
        begin
            int d [8] = '{1, 5, 2, 3, 4, 0, 7, -1};
            for (int i = 0; i < 8; i++) stim.push_back(32'(d[i]));
            exp_d.push_back(32'd5); exp_l.push_back(1'b0);
            exp_d.push_back(32'd7); exp_l.push_back(1'b1);
            stream(0, 100, 100, 0, -1, 0, 200);
        end

        // 2x2 directed frames: negatives, extremes, ties
        begin
            int d [16] = '{-8, -3, -5, -9,
                           32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000,
                           -1, 32'h7fffffff, 32'h7fffffff, -2,
                           -5, -5, -5, -5};
            int e [4] = '{-3, 32'h80000000, 32'h7fffffff, -5};
            for (int i = 0; i < 16; i++) stim.push_back(32'(d[i]));
            for (int i = 0; i < 4; i++) begin
                exp_d.push_back(32'(e[i]));
                exp_l.push_back(1'b1);
            end
            stream(1, 100, 100, 0, -1, 0, 200);
        end

        // 4x2 back-pressure: hold out_ready low 5 cycles on the first pending output
        rand_frame(); add_frame(4, 2);
        rand_frame(); add_frame(4, 2);
        stream(0, 100, 100, 5, -1, 0, 400);

        // 8x8 two back-to-back random frames, random handshakes
        rand_frame(); add_frame(8, 8);
        rand_frame(); add_frame(8, 8);
        stream(2, 70, 60, 0, -1, 0, 3000);
        chk("w8h8_exp_drained", 32'(exp_d.size()), 32'd0);

        // 8x8 with a 10-cycle in_valid gap mid-row
        rand_frame(); add_frame(8, 8);
        stream(2, 100, 100, 0, 3, 0, 1000);

        // 8x8 reset after 11 inputs, then a clean frame
        rand_frame(); add_frame(8, 8);
        stream(2, 100, 100, 0, -1, 11, 200);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(ov[2]), 32'd0);
        chk("midrst_out_last", 32'(ol[2]), 32'd0);
        chk("midrst_out_data", od[2], 32'd0);
        clear_model();
        rand_frame(); add_frame(8, 8);
        stream(2, 80, 70, 0, -1, 0, 2000);
        chk("post_rst_drained", 32'(exp_d.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
